// File: rtl/fifo_arbiter.sv
// Two-requester burst arbiter in front of a shared FIFO, with read strobe,
// one-cycle read-valid and a running occupancy count.
module fifo_arbiter #(
  parameter int unsigned DATAWIDTH  = 24,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BURST      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [DATAWIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATAWIDTH-1:0] req1_data,
  output logic                 req1_ready,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  output logic                 fifo_wr,
  output logic [DATAWIDTH-1:0] fifo_w_data,
  input  logic                 rd_req,
  output logic                 fifo_rd,
  output logic                 out_valid,
  output logic                 grant_id,
  output logic [ADDR_WIDTH:0]  level
);

  localparam int unsigned BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned LVL_W  = ADDR_WIDTH + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   last_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic                   out_valid_q;
  logic [LVL_W-1:0]       level_q;
  logic [LVL_W-1:0]       level_d;
  logic                   xfer0;
  logic                   xfer1;

  // Handshake, write/read strobes and write-data mux; reset forces all strobes low.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    xfer0       = 1'b0;
    xfer1       = 1'b0;
    fifo_wr     = 1'b0;
    fifo_w_data = wdata_q;
    fifo_rd     = 1'b0;
    req0_ready  = (state_q == SERVE0) && !fifo_full && !reset;
    req1_ready  = (state_q == SERVE1) && !fifo_full && !reset;
    xfer0       = req0_valid && req0_ready;
    xfer1       = req1_valid && req1_ready;
    fifo_wr     = xfer0 || xfer1;
    if (xfer0) begin
      fifo_w_data = req0_data;
    end else if (xfer1) begin
      fifo_w_data = req1_data;
    end
    fifo_rd     = rd_req && !fifo_empty && !reset;
  end

  // Occupancy next value: writes and reads cancel when simultaneous.
  always_comb begin
    level_d = level_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Arbitration FSM: round-robin between requesters, up to BURST words per grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid && (last_q || !req1_valid)) begin
            state_q <= SERVE0;
            beat_q  <= '0;
          end else if (req1_valid) begin
            state_q <= SERVE1;
            beat_q  <= '0;
          end
        end
        SERVE0: begin
          if (!fifo_full) begin
            if (req0_valid) begin
              if (beat_q == LAST_BEAT) begin
                last_q  <= 1'b0;
                beat_q  <= '0;
                state_q <= req1_valid ? SERVE1 : IDLE;
              end else begin
                beat_q <= beat_q + BEAT_W'(1);
              end
            end else begin
              last_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        SERVE1: begin
          if (!fifo_full) begin
            if (req1_valid) begin
              if (beat_q == LAST_BEAT) begin
                last_q  <= 1'b1;
                beat_q  <= '0;
                state_q <= req0_valid ? SERVE0 : IDLE;
              end else begin
                beat_q <= beat_q + BEAT_W'(1);
              end
            end else begin
              last_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Held write data, read-valid pipeline and occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
    end else begin
      if (fifo_wr) begin
        wdata_q <= fifo_w_data;
      end
      out_valid_q <= fifo_rd;
      level_q     <= level_d;
    end
  end

  assign grant_id  = (state_q == SERVE1);
  assign out_valid = out_valid_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: directed scenarios plus a random phase, all checked
// against a grant/queue-level model of the arbiter and its FIFO.
module tb_fifo_arbiter;

  localparam int unsigned DW    = 24;
  localparam int unsigned AW    = 10;
  localparam int          BURST = 4;
  localparam int          DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          v0, v1;
  logic [DW-1:0] d0, d1;
  logic          r0, r1;
  logic          fifo_full, fifo_empty;
  logic          fifo_wr;
  logic [DW-1:0] wd;
  logic          rd_req, fifo_rd, out_valid, grant_id;
  logic [AW:0]   level;

  fifo_arbiter #(.DATAWIDTH(DW), .ADDR_WIDTH(AW), .BURST(BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (v0),
    .req0_data  (d0),
    .req0_ready (r0),
    .req1_valid (v1),
    .req1_data  (d1),
    .req1_ready (r1),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_wr    (fifo_wr),
    .fifo_w_data(wd),
    .rd_req     (rd_req),
    .fifo_rd    (fifo_rd),
    .out_valid  (out_valid),
    .grant_id   (grant_id),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner 0/1 = granted requester, 2 = nobody; words counted per grant.
  int            m_owner;
  int            m_cnt;
  int            m_last;
  logic [DW-1:0] m_fifo[$];
  bit            m_outv;
  logic [DW-1:0] m_wdata;
  bit            force_full;
  bit            chk_en;
  int            checks;
  int            errors;
  int            n0, n1;
  logic          obs_r0, obs_r1, obs_wr, obs_rd, obs_gnt;
  logic [DW-1:0] obs_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO flags, check outputs mid-cycle, advance model, pass the edge.
  task automatic cycle();
    bit            e_r0, e_r1, e_wr, e_rd, e_g, mine, other;
    logic [DW-1:0] e_wd;
    fifo_full  = force_full || (m_fifo.size() >= DEPTH);
    fifo_empty = (m_fifo.size() == 0);
    #1;
    e_r0 = !reset && (m_owner == 0) && !fifo_full;
    e_r1 = !reset && (m_owner == 1) && !fifo_full;
    e_wr = (e_r0 && v0) || (e_r1 && v1);
    e_wd = !e_wr ? m_wdata : ((m_owner == 0) ? d0 : d1);
    e_rd = !reset && rd_req && !fifo_empty;
    e_g  = (m_owner == 1);
    obs_r0 = r0; obs_r1 = r1; obs_wr = fifo_wr; obs_rd = fifo_rd;
    obs_gnt = grant_id; obs_wd = wd;
    if (chk_en) begin
      chk("req0_ready", 32'(r0), 32'(e_r0));
      chk("req1_ready", 32'(r1), 32'(e_r1));
      chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
      chk("fifo_w_data", 32'(wd), 32'(e_wd));
      chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
      chk("grant_id", 32'(grant_id), 32'(e_g));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("level", 32'(level), 32'(m_fifo.size()));
    end
    if (reset) begin
      m_owner = 2; m_last = 1; m_cnt = 0; m_outv = 1'b0; m_wdata = '0;
      m_fifo.delete();
    end else begin
      m_outv = e_rd;
      if (e_rd) void'(m_fifo.pop_front());
      if (e_wr) begin
        m_fifo.push_back(e_wd);
        m_wdata = e_wd;
        if (m_owner == 0) n0++; else n1++;
      end
      if (m_owner == 2) begin
        if (v0 && (m_last == 1 || !v1)) begin m_owner = 0; m_cnt = 0; end
        else if (v1) begin m_owner = 1; m_cnt = 0; end
      end else if (!fifo_full) begin
        mine  = (m_owner == 0) ? v0 : v1;
        other = (m_owner == 0) ? v1 : v0;
        if (mine) begin
          m_cnt++;
          if (m_cnt == BURST) begin
            m_last  = m_owner;
            m_cnt   = 0;
            m_owner = other ? (1 - m_owner) : 2;
          end
        end else begin
          m_last  = m_owner;
          m_owner = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; rd_req = 1'b0; force_full = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sz;
    bit done;
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; rd_req = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1; force_full = 1'b0;
    m_owner = 2; m_cnt = 0; m_last = 1; m_outv = 1'b0; m_wdata = '0;
    checks = 0; errors = 0; n0 = 0; n1 = 0; chk_en = 1'b0;
    @(posedge clk); #1;
    cycle();
    chk_en = 1'b1;

    // Reset state with requests and a read pending: everything held quiet.
    v0 = 1'b1; v1 = 1'b1; rd_req = 1'b1;
    cycle();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);

    // Both valid from reset: one idle cycle, 4 words from req0, then 4 from req1.
    reset = 1'b0; rd_req = 1'b0; n0 = 0; n1 = 0;
    for (int i = 1; i <= 10; i++) begin
      d0 = DW'(n0 + 1);
      d1 = DW'(32'h100000 + n1 + 1);
      cycle();
      chk($sformatf("alt_wr_c%0d", i), 32'(obs_wr), (i == 1) ? 32'd0 : 32'd1);
      chk($sformatf("alt_gnt_c%0d", i), 32'(obs_gnt), (i >= 6 && i <= 9) ? 32'd1 : 32'd0);
      if (i >= 2 && i <= 5) chk($sformatf("alt_data_c%0d", i), 32'(obs_wd), 32'(i - 1));
    end

    // req0 alone: 2 words, drop, then req1 gets the grant after one idle cycle.
    do_reset();
    v0 = 1'b1; d0 = DW'(24'hA0A0A0);
    cycle(); cycle(); cycle();
    v0 = 1'b0;
    cycle();
    chk("solo_idle_gnt", 32'(grant_id), 32'd0);
    v1 = 1'b1; d1 = DW'(24'hB1B1B1);
    cycle();
    chk("solo_serve1_gnt", 32'(grant_id), 32'd1);
    chk("solo_level", 32'(level), 32'd2);
    v1 = 1'b0;
    cycle();

    // FIFO full for 3 cycles mid-burst: burst freezes, then completes 4 words.
    do_reset();
    v0 = 1'b1; d0 = DW'(24'h123456);
    cycle(); cycle(); cycle();
    force_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("full_wr_c%0d", i), 32'(obs_wr), 32'd0);
      chk($sformatf("full_rdy_c%0d", i), 32'(obs_r0), 32'd0);
    end
    chk("full_level", 32'(level), 32'd2);
    force_full = 1'b0;
    cycle(); cycle(); cycle();
    chk("full_burst_level", 32'(level), 32'd4);
    v0 = 1'b0;
    cycle();

    // Simultaneous write and read at level 5.
    do_reset();
    v0 = 1'b1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      d0 = DW'($urandom);
      sz = m_fifo.size();
      rd_req = (sz == 5);
      cycle();
      if (sz == 5 && obs_wr && obs_rd) done = 1'b1;
    end
    chk("both_seen", 32'(done), 32'd1);
    chk("both_level", 32'(level), 32'd5);
    chk("both_out_valid", 32'(out_valid), 32'd1);
    v0 = 1'b0; rd_req = 1'b0;
    cycle();

    // Read request while empty.
    do_reset();
    rd_req = 1'b1;
    cycle();
    chk("empty_rd", 32'(obs_rd), 32'd0);
    chk("empty_out_valid", 32'(out_valid), 32'd0);
    chk("empty_level", 32'(level), 32'd0);
    rd_req = 1'b0;

    // Reset during SERVE1 after 2 beats.
    do_reset();
    v1 = 1'b1; d1 = DW'(24'h00BEEF);
    cycle(); cycle(); cycle();
    chk("midrst_pre_gnt", 32'(grant_id), 32'd1);
    reset = 1'b1; v0 = 1'b1; rd_req = 1'b1;
    cycle();
    chk("midrst_rd", 32'(obs_rd), 32'd0);
    chk("midrst_rdy1", 32'(obs_r1), 32'd0);
    chk("midrst_gnt", 32'(grant_id), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0; rd_req = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v0         = 1'($urandom_range(0, 1));
      v1         = 1'($urandom_range(0, 1));
      d0         = DW'($urandom);
      d1         = DW'($urandom);
      rd_req     = 1'($urandom_range(0, 1));
      force_full = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
